id_stage: RTL
=============

Name: id_stage

Overview:
- Instruction-decode stage directly downstream of the fetch unit.
- Latches the fetched instruction and next_pc into an IF/ID register, with stall and flush controls.
- Reads the 32x32 register file and decodes control signals for the execute stage.
- Returns jmp, jr, jr_addr and beq to the fetch unit.

Parameters:
- DATA_W, 32, datapath and register width.
- NUM_REGS, 32, register-file depth; register 0 is hardwired to zero.
- ADDR_W, 5, register address width.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_instruction  in  32  instruction from the fetch unit.
- if_next_pc  in  32  fetch next_pc (pc+4).
- stall  in  1  hold the IF/ID register.
- flush  in  1  invalidate the IF/ID register (bubble).
- wb_we  in  1  register-file write enable.
- wb_addr  in  5  write-back register index.
- wb_data  in  32  write-back data.
- id_valid  out  1  latched slot holds a real instruction.
- id_instruction  out  32  latched instruction.
- id_next_pc  out  32  latched next_pc.
- rs_data  out  32  register[instr[25:21]].
- rt_data  out  32  register[instr[20:16]].
- imm_ext  out  32  immediate: sign-extended, except ori which is zero-extended.
- dst_addr  out  5  rd for R-type, rt for I-type loads/ALU ops, 0 otherwise.
- reg_write, mem_read, mem_write, mem_to_reg, alu_src  out  1 each  execute/memory controls.
- alu_op  out  4  0=ADD 1=SUB 2=AND 3=OR 4=SLT 5=LUI.
- jmp, jr, beq  out  1 each  to the fetch unit.
- jr_addr  out  32  equals rs_data.
- illegal  out  1  valid slot holds an undecodable instruction.

Behaviour:
- IF/ID register, evaluated on each rising clock edge in priority order:
  - reset: valid=0, instruction=0, next_pc=0.
  - flush: valid=0, instruction=0, next_pc held.
  - stall: all fields held.
  - otherwise: capture if_instruction and if_next_pc, valid=1.
  - flush overrides stall; reset overrides both.
- Register file:
  - reset clears all entries to 0.
  - Write on the rising edge when wb_we=1 and wb_addr!=0; writes to r0 are ignored and r0 always reads 0.
  - Reads are combinational from the latched instruction.
  - Without the bypass option, a same-cycle write returns the old value; the new value is visible from the next cycle.
  - Writes proceed during stall and flush.
- Decode is purely combinational from the latched instruction; decode latency is 0 cycles after the latch, so 1 cycle from if_instruction.
- Opcodes:
  - 000000 R-type, by funct:
    - 100000 add: alu_op=ADD, reg_write=1, dst=rd.
    - 100010 sub: alu_op=SUB, reg_write=1, dst=rd.
    - 100100 and: alu_op=AND, reg_write=1, dst=rd.
    - 100101 or: alu_op=OR, reg_write=1, dst=rd.
    - 101010 slt: alu_op=SLT, reg_write=1, dst=rd.
    - 001000 jr: jr=1, no register write.
  - 100011 lw: mem_read, mem_to_reg, alu_src, reg_write, ADD, dst=rt.
  - 101011 sw: mem_write, alu_src, ADD.
  - 000100 beq: beq=1, alu_op=SUB.
  - 000010 j: jmp=1.
  - 001000 addi: alu_src, reg_write, ADD, dst=rt.
  - 001101 ori: alu_src, reg_write, OR, dst=rt, zero-extended immediate.
  - 001111 lui: alu_src, reg_write, LUI, dst=rt.
- Illegal encodings and the all-zero word (sll 0 = nop):
  - Any other opcode/funct: all controls 0 and illegal=1.
  - All-zero word: a legal NOP; all controls 0 and illegal=0.
- When id_valid=0, every control output, including illegal, is 0. Data outputs still reflect the latched, zeroed instruction.
- Reset mid-operation discards the latched instruction and clears all registers on that edge; the first valid slot appears 1 cycle after reset deasserts.

Optional Feature:
- Macro ID_WB_BYPASS_EN.
- When defined, rs_data and rt_data return wb_data in the same cycle when wb_we=1, wb_addr!=0 and the read index equals wb_addr (write-first). jr_addr follows rs_data.
- When undefined, reads return the pre-write register contents.

Decomposition:
- Shared definitions file cpu_defs holds:
  - opcode and funct constants;
  - alu_op encodings (ADD..LUI);
  - DATA_W and ADDR_W.
- The execute-stage ALU and the fetch unit include the same file.
- One sub-module, regfile: 2 read ports, 1 write port, synchronous reset, r0 hardwired, with the bypass gated by the macro.

Test Plan:
- Reset, then idle with if_instruction=0x00000000 -> id_valid=1 next cycle; all controls 0; illegal=0.
- Write r8=0x12345678 via WB, then latch add $t1,$t0,$t0 (0x01084820) -> rs_data=rt_data=0x12345678, dst_addr=9, reg_write=1, alu_op=0.
- Latch beq offset 0xFFFF (0x1000FFFF) -> beq=1, imm_ext=0xFFFFFFFF. Latch ori (0x3508FFFF) -> imm_ext=0x0000FFFF, alu_op=3.
- With r31=0x40, latch jr $ra (0x03E00008) -> jr=1, jr_addr=0x40. Assert stall 3 cycles while changing if_instruction -> outputs unchanged. Assert stall+flush together -> id_valid=0, jr=0.
- Write wb_addr=0 data 0xFFFFFFFF -> r0 still reads 0. Write r5 in the same cycle as a read of r5 -> new value with ID_WB_BYPASS_EN, old value without.
- Latch opcode 111111 -> illegal=1, all controls 0. Assert reset mid-stream -> all registers 0 and id_valid=0 on the next edge.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared CPU definitions for the decode stage: widths, opcode/funct
// constants, ALU operation encodings and the decoded-control bundle.
// The execute-stage ALU and the fetch unit import the same package.
package id_stage_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_LUI = 4'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_RD   = 2'd1,
        DST_RT   = 2'd2
    } dst_sel_e;

    typedef struct packed {
        logic     reg_write;
        logic     mem_read;
        logic     mem_write;
        logic     mem_to_reg;
        logic     alu_src;
        alu_op_e  alu_op;
        logic     jmp;
        logic     jr;
        logic     beq;
        logic     illegal;
        dst_sel_e dst_sel;
    } ctrl_t;

    // Immediate extension: ori zero-extends, everything else sign-extends.
    function automatic logic [DATA_W-1:0] ext_imm(input logic [5:0] op,
                                                  input logic [15:0] imm);
        if (op == OP_ORI) begin
            return {16'h0000, imm};
        end else begin
            return {{16{imm[15]}}, imm};
        end
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch <-> decode bus: instruction/next_pc forward, redirect info back.
interface id_stage_if;
    import id_stage_pkg::*;

    logic [DATA_W-1:0] if_instruction;
    logic [DATA_W-1:0] if_next_pc;
    logic              jmp;
    logic              jr;
    logic              beq;
    logic [DATA_W-1:0] jr_addr;

    modport master (output if_instruction, output if_next_pc,
                    input  jmp, input jr, input beq, input jr_addr);
    modport slave  (input  if_instruction, input if_next_pc,
                    output jmp, output jr, output beq, output jr_addr);
endinterface

// File: rtl/id_stage_regfile.sv
// 32x32 register file, 2 combinational read ports, 1 write port.
// r0 is never written and always reads zero. Optional write-first
// bypass is enabled by defining ID_WB_BYPASS_EN.
module id_stage_regfile
    import id_stage_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic [DATA_W-1:0] stored_a_s;
    logic [DATA_W-1:0] stored_b_s;
    logic              byp_a_s;
    logic              byp_b_s;

    // Register storage: clear on reset, otherwise write non-zero index.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we && (waddr != {ADDR_W{1'b0}})) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign stored_a_s = (raddr_a == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : regs_r[raddr_a];
    assign stored_b_s = (raddr_b == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : regs_r[raddr_b];

`ifdef ID_WB_BYPASS_EN
    assign byp_a_s = we && (waddr != {ADDR_W{1'b0}}) && (raddr_a == waddr);
    assign byp_b_s = we && (waddr != {ADDR_W{1'b0}}) && (raddr_b == waddr);
`else
    assign byp_a_s = 1'b0;
    assign byp_b_s = 1'b0;
`endif

    assign rdata_a = byp_a_s ? wdata : stored_a_s;
    assign rdata_b = byp_b_s ? wdata : stored_b_s;
endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register with stall/flush, register
// file read, and combinational control decode for execute and fetch.
// Optional macro: ID_WB_BYPASS_EN (write-first register-file bypass).
module id_stage
    import id_stage_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    id_stage_if.slave         fetch,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instruction,
    output logic [DATA_W-1:0] id_next_pc,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] imm_ext,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              alu_src,
    output logic [3:0]        alu_op,
    output logic              illegal
);
    logic              valid_r;
    logic [DATA_W-1:0] instr_r;
    logic [DATA_W-1:0] npc_r;
    ctrl_t             dec_s;
    ctrl_t             ctrl_s;
    logic [5:0]        op_s;
    logic [5:0]        fn_s;

    // IF/ID register: reset > flush > stall > capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r <= 1'b0;
            instr_r <= '0;
            npc_r   <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
            instr_r <= '0;
        end else if (!stall) begin
            valid_r <= 1'b1;
            instr_r <= fetch.if_instruction;
            npc_r   <= fetch.if_next_pc;
        end
    end

    id_stage_regfile u_regfile (
        .clock   (clock),
        .reset   (reset),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (instr_r[25:21]),
        .raddr_b (instr_r[20:16]),
        .rdata_a (rs_data),
        .rdata_b (rt_data)
    );

    assign op_s = instr_r[31:26];
    assign fn_s = instr_r[5:0];

    // Control decode of the latched word; unknown encodings flag illegal.
    always_comb begin
        dec_s = '0;
        case (op_s)
            OP_RTYPE: begin
                case (fn_s)
                    FN_ADD: begin dec_s.reg_write = 1'b1; dec_s.alu_op = ALU_ADD; dec_s.dst_sel = DST_RD; end
                    FN_SUB: begin dec_s.reg_write = 1'b1; dec_s.alu_op = ALU_SUB; dec_s.dst_sel = DST_RD; end
                    FN_AND: begin dec_s.reg_write = 1'b1; dec_s.alu_op = ALU_AND; dec_s.dst_sel = DST_RD; end
                    FN_OR:  begin dec_s.reg_write = 1'b1; dec_s.alu_op = ALU_OR;  dec_s.dst_sel = DST_RD; end
                    FN_SLT: begin dec_s.reg_write = 1'b1; dec_s.alu_op = ALU_SLT; dec_s.dst_sel = DST_RD; end
                    FN_JR:  begin dec_s.jr = 1'b1; end
                    // The all-zero word is the canonical NOP and stays legal.
                    default: dec_s.illegal = (instr_r != {DATA_W{1'b0}});
                endcase
            end
            OP_LW: begin
                dec_s.mem_read   = 1'b1;
                dec_s.mem_to_reg = 1'b1;
                dec_s.alu_src    = 1'b1;
                dec_s.reg_write  = 1'b1;
                dec_s.alu_op     = ALU_ADD;
                dec_s.dst_sel    = DST_RT;
            end
            OP_SW: begin
                dec_s.mem_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                dec_s.beq    = 1'b1;
                dec_s.alu_op = ALU_SUB;
            end
            OP_J: begin
                dec_s.jmp = 1'b1;
            end
            OP_ADDI: begin dec_s.alu_src = 1'b1; dec_s.reg_write = 1'b1; dec_s.alu_op = ALU_ADD; dec_s.dst_sel = DST_RT; end
            OP_ORI:  begin dec_s.alu_src = 1'b1; dec_s.reg_write = 1'b1; dec_s.alu_op = ALU_OR;  dec_s.dst_sel = DST_RT; end
            OP_LUI:  begin dec_s.alu_src = 1'b1; dec_s.reg_write = 1'b1; dec_s.alu_op = ALU_LUI; dec_s.dst_sel = DST_RT; end
            default: dec_s.illegal = 1'b1;
        endcase
    end

    // Bubbles drive every control low, including illegal.
    always_comb begin
        if (valid_r) begin
            ctrl_s = dec_s;
        end else begin
            ctrl_s = '0;
        end
    end

    // Destination register selection from the gated controls.
    always_comb begin
        dst_addr = '0;
        case (ctrl_s.dst_sel)
            DST_RD:  dst_addr = instr_r[15:11];
            DST_RT:  dst_addr = instr_r[20:16];
            default: dst_addr = '0;
        endcase
    end

    assign id_valid       = valid_r;
    assign id_instruction = instr_r;
    assign id_next_pc     = npc_r;
    assign imm_ext        = ext_imm(op_s, instr_r[15:0]);
    assign reg_write      = ctrl_s.reg_write;
    assign mem_read       = ctrl_s.mem_read;
    assign mem_write      = ctrl_s.mem_write;
    assign mem_to_reg     = ctrl_s.mem_to_reg;
    assign alu_src        = ctrl_s.alu_src;
    assign alu_op         = ctrl_s.alu_op;
    assign illegal        = ctrl_s.illegal;
    assign fetch.jmp      = ctrl_s.jmp;
    assign fetch.jr       = ctrl_s.jr;
    assign fetch.beq      = ctrl_s.beq;
    assign fetch.jr_addr  = rs_data;
endmodule
